// File: rtl/sram_arbiter_pkg.sv
// Shared state encodings and constants for the instruction/data SRAM arbiter.
// The optional instruction buffer is enabled with the ARB_IBUF_EN macro.
package sram_arbiter_pkg;
  typedef enum logic [1:0] {
    ArbIdle = 2'd0,
    ArbDAcc = 2'd1,
    ArbIAcc = 2'd2,
    ArbDone = 2'd3
  } arb_state_e;

  localparam logic [3:0] ArbSelAll = 4'b1111;
endpackage

// File: rtl/sram_arbiter_if.sv
// Core-side request ports and SRAM-side bus of the arbiter.
// ARB_IBUF_EN does not change this interface.
interface sram_arbiter_if;
  // Handshake: a request (if_ce_i / dm_ce_i) plus its address/data is held stable
  // by the core while stallreq_o is high; the request is complete and its result
  // valid in the first cycle where stallreq_o is low, at whose edge the core advances.
  logic        if_ce_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_data_o;
  logic        dm_ce_i;
  logic        dm_we_i;
  logic [3:0]  dm_sel_i;
  logic [31:0] dm_addr_i;
  logic [31:0] dm_wdata_i;
  logic [31:0] dm_rdata_o;
  logic        stallreq_o;
  logic        sram_ce_o;
  logic        sram_we_o;
  logic [3:0]  sram_sel_o;
  logic [31:0] sram_addr_o;
  logic [31:0] sram_wdata_o;
  logic [31:0] sram_rdata_i;

  modport slave (
    input  if_ce_i, if_addr_i, dm_ce_i, dm_we_i, dm_sel_i, dm_addr_i, dm_wdata_i,
    input  sram_rdata_i,
    output if_data_o, dm_rdata_o, stallreq_o,
    output sram_ce_o, sram_we_o, sram_sel_o, sram_addr_o, sram_wdata_o
  );

  modport master (
    output if_ce_i, if_addr_i, dm_ce_i, dm_we_i, dm_sel_i, dm_addr_i, dm_wdata_i,
    output sram_rdata_i,
    input  if_data_o, dm_rdata_o, stallreq_o,
    input  sram_ce_o, sram_we_o, sram_sel_o, sram_addr_o, sram_wdata_o
  );
endinterface

// File: rtl/sram_arbiter_ibuf.sv
// One-entry instruction buffer for the SRAM arbiter; only built when ARB_IBUF_EN
// is defined. Filled on every fetch completion, invalidated by writes to its tag.
`ifdef ARB_IBUF_EN
module sram_arbiter_ibuf (
  input  logic        clk,
  input  logic        rst,
  input  logic        fill_i,
  input  logic [29:0] fill_tag_i,
  input  logic [31:0] fill_data_i,
  input  logic        inval_i,
  input  logic [29:0] inval_tag_i,
  input  logic [29:0] look_tag_i,
  input  logic        dm_wr_i,
  input  logic [29:0] dm_tag_i,
  output logic        hit_o,
  output logic [31:0] data_o
);
  logic        valid_q;
  logic [29:0] tag_q;
  logic [31:0] data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else if (fill_i) begin
      valid_q <= 1'b1;
      tag_q   <= fill_tag_i;
      data_q  <= fill_data_i;
    end else if (inval_i && inval_tag_i == tag_q) begin
      valid_q <= 1'b0;
    end
  end

  // A pending write to the buffered word must not be bypassed by a stale hit.
  assign hit_o  = valid_q && (look_tag_i == tag_q) && !(dm_wr_i && dm_tag_i == tag_q);
  assign data_o = data_q;
endmodule
`endif

// File: rtl/sram_arbiter.sv
// Shares one single-ported SRAM between instruction fetch and data access, data
// first, with a fixed WAIT_CYCLES access. ARB_IBUF_EN adds a one-entry fetch buffer.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst,
  sram_arbiter_if.slave bus,
  output arb_state_e    state_o
);
  localparam logic [2:0] CntInit = 3'(WAIT_CYCLES - 1);

  arb_state_e  state_q;
  logic [2:0]  cnt_q;
  logic        d_done_q, i_done_q;
  logic        sram_ce_q, sram_we_q;
  logic [3:0]  sram_sel_q;
  logic [31:0] sram_addr_q, sram_wdata_q;
  logic [31:0] dm_rdata_q, if_data_q;
  logic        ibuf_hit, d_pend, i_pend, acc_last;

  assign acc_last = (cnt_q == 3'd0);

`ifdef ARB_IBUF_EN
  logic [31:0] ibuf_data;

  sram_arbiter_ibuf u_ibuf (
    .clk        (clk),
    .rst        (rst),
    .fill_i     (state_q == ArbIAcc && acc_last),
    .fill_tag_i (sram_addr_q[31:2]),
    .fill_data_i(bus.sram_rdata_i),
    .inval_i    (state_q == ArbDAcc && acc_last && sram_we_q),
    .inval_tag_i(sram_addr_q[31:2]),
    .look_tag_i (bus.if_addr_i[31:2]),
    .dm_wr_i    (bus.dm_ce_i & bus.dm_we_i),
    .dm_tag_i   (bus.dm_addr_i[31:2]),
    .hit_o      (ibuf_hit),
    .data_o     (ibuf_data)
  );
  assign bus.if_data_o = ibuf_hit ? ibuf_data : if_data_q;
`else
  assign ibuf_hit      = 1'b0;
  assign bus.if_data_o = if_data_q;
`endif

  assign d_pend         = bus.dm_ce_i & ~d_done_q;
  assign i_pend         = bus.if_ce_i & ~i_done_q & ~ibuf_hit;
  assign bus.stallreq_o = d_pend | i_pend;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ArbIdle;
      cnt_q        <= '0;
      d_done_q     <= 1'b0;
      i_done_q     <= 1'b0;
      sram_ce_q    <= 1'b0;
      sram_we_q    <= 1'b0;
      sram_sel_q   <= '0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
      dm_rdata_q   <= '0;
      if_data_q    <= '0;
    end else begin
      case (state_q)
        ArbIdle: begin
          if (d_pend) begin
            state_q      <= ArbDAcc;
            cnt_q        <= CntInit;
            sram_ce_q    <= 1'b1;
            sram_we_q    <= bus.dm_we_i;
            sram_sel_q   <= bus.dm_we_i ? bus.dm_sel_i : ArbSelAll;
            sram_addr_q  <= bus.dm_addr_i;
            sram_wdata_q <= bus.dm_wdata_i;
          end else if (i_pend) begin
            state_q     <= ArbIAcc;
            cnt_q       <= CntInit;
            sram_ce_q   <= 1'b1;
            sram_we_q   <= 1'b0;
            sram_sel_q  <= ArbSelAll;
            sram_addr_q <= bus.if_addr_i;
          end
        end
        ArbDAcc: begin
          if (acc_last) begin
            d_done_q  <= 1'b1;
            sram_ce_q <= 1'b0;
            sram_we_q <= 1'b0;
            if (!sram_we_q) dm_rdata_q <= bus.sram_rdata_i;
            // Fetch reload overrides the control drop above.
            if (i_pend) begin
              state_q     <= ArbIAcc;
              cnt_q       <= CntInit;
              sram_ce_q   <= 1'b1;
              sram_sel_q  <= ArbSelAll;
              sram_addr_q <= bus.if_addr_i;
            end else begin
              state_q <= ArbDone;
            end
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        ArbIAcc: begin
          if (acc_last) begin
            i_done_q  <= 1'b1;
            sram_ce_q <= 1'b0;
            sram_we_q <= 1'b0;
            if_data_q <= bus.sram_rdata_i;
            state_q   <= ArbDone;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        ArbDone: begin
          d_done_q <= 1'b0;
          i_done_q <= 1'b0;
          state_q  <= ArbIdle;
        end
        default: state_q <= ArbIdle;
      endcase
    end
  end

  assign bus.sram_ce_o    = sram_ce_q;
  assign bus.sram_we_o    = sram_we_q;
  assign bus.sram_sel_o   = sram_sel_q;
  assign bus.sram_addr_o  = sram_addr_q;
  assign bus.sram_wdata_o = sram_wdata_q;
  assign bus.dm_rdata_o   = dm_rdata_q;
  assign state_o          = state_q;
endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter (WAIT_CYCLES=2 and =1 instances) with a word SRAM model.
// Buffer scenarios are included when ARB_IBUF_EN is defined.
module tb_sram_arbiter;
  import sram_arbiter_pkg::*;

  logic clk;
  logic rst;
  arb_state_e state, state1;
  int tests_run, tests_failed;
  int stall_n, we_n;
  logic [31:0] addr_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] mem [0:255];

  sram_arbiter_if bif ();
  sram_arbiter_if bif1 ();

  sram_arbiter #(.WAIT_CYCLES(2)) dut  (.clk(clk), .rst(rst), .bus(bif),  .state_o(state));
  sram_arbiter #(.WAIT_CYCLES(1)) dut1 (.clk(clk), .rst(rst), .bus(bif1), .state_o(state1));

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: combinational read, byte-enabled write on the clock edge
  assign bif.sram_rdata_i  = bif.sram_ce_o  ? mem[bif.sram_addr_o[9:2]]  : 32'hBAD0_BAD0;
  assign bif1.sram_rdata_i = bif1.sram_ce_o ? mem[bif1.sram_addr_o[9:2]] : 32'hBAD0_BAD0;
  always @(posedge clk) begin
    if (bif.sram_ce_o && bif.sram_we_o)
      for (int b = 0; b < 4; b++)
        if (bif.sram_sel_o[b]) mem[bif.sram_addr_o[9:2]][8*b +: 8] = bif.sram_wdata_o[8*b +: 8];
  end

  function automatic bit queues_equal(input logic [31:0] a[$], input logic [31:0] b[$]);
    if (a.size() != b.size()) return 1'b0;
    for (int i = 0; i < a.size(); i++) if (a[i] !== b[i]) return 1'b0;
    return 1'b1;
  endfunction

  // Driver tasks
  task automatic drive_idle();
    bif.if_ce_i = 0; bif.if_addr_i = 0; bif.dm_ce_i = 0; bif.dm_we_i = 0;
    bif.dm_sel_i = 0; bif.dm_addr_i = 0; bif.dm_wdata_i = 0;
    bif1.if_ce_i = 0; bif1.if_addr_i = 0; bif1.dm_ce_i = 0; bif1.dm_we_i = 0;
    bif1.dm_sel_i = 0; bif1.dm_addr_i = 0; bif1.dm_wdata_i = 0;
  endtask

  // Called right after driving at a negedge; returns sampling in the first unstalled cycle.
  task automatic serve();
    stall_n = 0; we_n = 0; addr_q.delete();
    for (int c = 0; c < 20; c++) begin
      #1;
      if (bif.sram_ce_o) begin
        addr_q.push_back(bif.sram_addr_o);
        if (bif.sram_we_o && bif.sram_sel_o == 4'b0011) we_n++;
      end
      if (!bif.stallreq_o) break;
      stall_n++;
      @(negedge clk);
    end
  endtask

  task automatic serve1();
    stall_n = 0; addr_q.delete();
    for (int c = 0; c < 20; c++) begin
      #1;
      if (bif1.sram_ce_o) addr_q.push_back(bif1.sram_addr_o);
      if (!bif1.stallreq_o) break;
      stall_n++;
      @(negedge clk);
    end
  endtask

  task automatic drop_req();
    @(negedge clk);
    drive_idle();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
    repeat (2) @(negedge clk);
    #1;
    tests_run++;
    if ({bif.sram_ce_o, bif.sram_we_o, bif.sram_sel_o} !== 6'd0) begin
      tests_failed++; $display("FAIL reset_ctl: got %b expected 000000", {bif.sram_ce_o, bif.sram_we_o, bif.sram_sel_o});
    end
    tests_run++;
    if ({bif.sram_addr_o, bif.sram_wdata_o} !== 64'd0) begin
      tests_failed++; $display("FAIL reset_bus: got %h expected 0", {bif.sram_addr_o, bif.sram_wdata_o});
    end
    tests_run++;
    if ({bif.if_data_o, bif.dm_rdata_o} !== 64'd0) begin
      tests_failed++; $display("FAIL reset_hold: got %h expected 0", {bif.if_data_o, bif.dm_rdata_o});
    end
    tests_run++;
    if (bif.stallreq_o !== 1'b0) begin
      tests_failed++; $display("FAIL reset_stall: got %b expected 0", bif.stallreq_o);
    end
    tests_run++;
    if (state !== ArbIdle) begin
      tests_failed++; $display("FAIL reset_state: got %0d expected %0d", state, ArbIdle);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_idle();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      tests_run++;
      if ({bif.stallreq_o, bif.sram_ce_o} !== 2'b00) begin
        tests_failed++; $display("FAIL idle_quiet: got %b expected 00", {bif.stallreq_o, bif.sram_ce_o});
      end
    end
  endtask

  task automatic test_fetch_only();
    mem[4] = 32'h3401_1100;
    @(negedge clk);
    bif.if_ce_i = 1; bif.if_addr_i = 32'h0000_0010;
    serve();
    exp_q = '{32'h10, 32'h10};
    tests_run++;
    if (stall_n != 3) begin tests_failed++; $display("FAIL fetch_stall: got %0d expected 3", stall_n); end
    tests_run++;
    if (!queues_equal(addr_q, exp_q)) begin
      tests_failed++; $display("FAIL fetch_addr: got %0d accesses expected 2 at 0x10", addr_q.size());
    end
    tests_run++;
    if (bif.if_data_o !== 32'h3401_1100) begin
      tests_failed++; $display("FAIL fetch_data: got %h expected 34011100", bif.if_data_o);
    end
    tests_run++;
    if (state !== ArbDone) begin tests_failed++; $display("FAIL fetch_done: got %0d expected %0d", state, ArbDone); end
    drop_req();
  endtask

  task automatic test_data_fetch();
    mem[8'h40] = 32'hDEAD_BEEF;
    mem[5]     = 32'h2402_0005;
    @(negedge clk);
    bif.dm_ce_i = 1; bif.dm_we_i = 0; bif.dm_addr_i = 32'h100;
    bif.if_ce_i = 1; bif.if_addr_i = 32'h14;
    serve();
    exp_q = '{32'h100, 32'h100, 32'h14, 32'h14};
    tests_run++;
    if (stall_n != 5) begin tests_failed++; $display("FAIL df_stall: got %0d expected 5", stall_n); end
    tests_run++;
    if (!queues_equal(addr_q, exp_q)) begin
      tests_failed++; $display("FAIL df_order: got %0d accesses expected 100,100,14,14", addr_q.size());
    end
    tests_run++;
    if (bif.dm_rdata_o !== 32'hDEAD_BEEF) begin
      tests_failed++; $display("FAIL df_rdata: got %h expected deadbeef", bif.dm_rdata_o);
    end
    tests_run++;
    if (bif.if_data_o !== 32'h2402_0005) begin
      tests_failed++; $display("FAIL df_idata: got %h expected 24020005", bif.if_data_o);
    end
    drop_req();
  endtask

  task automatic test_write();
    mem[8'h80] = 32'hFFFF_FFFF;
    @(negedge clk);
    bif.dm_ce_i = 1; bif.dm_we_i = 1; bif.dm_sel_i = 4'b0011;
    bif.dm_addr_i = 32'h200; bif.dm_wdata_i = 32'h0000_ABCD;
    serve();
    tests_run++;
    if (stall_n != 3) begin tests_failed++; $display("FAIL wr_stall: got %0d expected 3", stall_n); end
    tests_run++;
    if (we_n != 2) begin tests_failed++; $display("FAIL wr_we_sel: got %0d cycles expected 2", we_n); end
    tests_run++;
    if (mem[8'h80] !== 32'hFFFF_ABCD) begin
      tests_failed++; $display("FAIL wr_commit: got %h expected ffffabcd", mem[8'h80]);
    end
    tests_run++;
    if (bif.dm_rdata_o !== 32'hDEAD_BEEF) begin
      tests_failed++; $display("FAIL wr_rdata_hold: got %h expected deadbeef", bif.dm_rdata_o);
    end
    drop_req();
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bif.dm_ce_i = 1; bif.dm_we_i = 0; bif.dm_addr_i = 32'h100;
    repeat (2) @(negedge clk);
    #1;
    tests_run++;
    if (state !== ArbDAcc) begin tests_failed++; $display("FAIL rm_pre: got %0d expected %0d", state, ArbDAcc); end
    rst = 1'b1;
    #1;
    tests_run++;
    if ({bif.sram_ce_o, bif.sram_we_o, bif.sram_sel_o, bif.sram_addr_o, bif.sram_wdata_o} !== 70'd0) begin
      tests_failed++; $display("FAIL rm_abort: got ce=%b addr=%h expected all zero", bif.sram_ce_o, bif.sram_addr_o);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests_run++;
    if ({state, bif.stallreq_o} !== {ArbIdle, 1'b1}) begin
      tests_failed++; $display("FAIL rm_restart: got state=%0d stall=%b expected 0/1", state, bif.stallreq_o);
    end
    serve();
    tests_run++;
    if (stall_n != 3) begin tests_failed++; $display("FAIL rm_stall: got %0d expected 3", stall_n); end
    tests_run++;
    if (bif.dm_rdata_o !== 32'hDEAD_BEEF) begin
      tests_failed++; $display("FAIL rm_rdata: got %h expected deadbeef", bif.dm_rdata_o);
    end
    drop_req();
  endtask

`ifdef ARB_IBUF_EN
  task automatic test_ibuf();
    mem[8] = 32'h1111_2222;
    @(negedge clk);
    bif.if_ce_i = 1; bif.if_addr_i = 32'h20;
    serve();
    tests_run++;
    if (stall_n != 3) begin tests_failed++; $display("FAIL ib_miss: got %0d expected 3", stall_n); end
    drop_req();
    @(negedge clk);
    bif.if_ce_i = 1; bif.if_addr_i = 32'h20;
    #1;
    tests_run++;
    if ({bif.stallreq_o, bif.sram_ce_o, bif.if_data_o} !== {2'b00, 32'h1111_2222}) begin
      tests_failed++; $display("FAIL ib_hit: got stall=%b ce=%b data=%h expected 0 0 11112222",
                               bif.stallreq_o, bif.sram_ce_o, bif.if_data_o);
    end
    @(negedge clk); #1;
    tests_run++;
    if ({state, bif.sram_ce_o} !== {ArbIdle, 1'b0}) begin
      tests_failed++; $display("FAIL ib_nosram: got state=%0d ce=%b expected 0 0", state, bif.sram_ce_o);
    end
    drop_req();
    @(negedge clk);
    bif.dm_ce_i = 1; bif.dm_we_i = 1; bif.dm_sel_i = 4'b1111;
    bif.dm_addr_i = 32'h20; bif.dm_wdata_i = 32'h5555_6666;
    serve();
    drop_req();
    @(negedge clk);
    bif.if_ce_i = 1; bif.if_addr_i = 32'h20;
    serve();
    exp_q = '{32'h20, 32'h20};
    tests_run++;
    if (stall_n != 3 || !queues_equal(addr_q, exp_q)) begin
      tests_failed++; $display("FAIL ib_inval: got stall=%0d accesses=%0d expected 3 2", stall_n, addr_q.size());
    end
    tests_run++;
    if (bif.if_data_o !== 32'h5555_6666) begin
      tests_failed++; $display("FAIL ib_newdata: got %h expected 55556666", bif.if_data_o);
    end
    drop_req();
  endtask
`endif

  task automatic test_back_to_back();
    logic [31:0] exp_d;
    mem[0] = 32'h1000_0000; mem[1] = 32'h1000_0001; mem[2] = 32'h1000_0002;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bif1.if_ce_i = 1; bif1.if_addr_i = 32'(4 * k);
      exp_d = 32'h1000_0000 + 32'(k);
      serve1();
      exp_q = '{32'(4 * k)};
      tests_run++;
      if (stall_n != 2) begin tests_failed++; $display("FAIL b2b_stall[%0d]: got %0d expected 2", k, stall_n); end
      tests_run++;
      if (!queues_equal(addr_q, exp_q)) begin
        tests_failed++; $display("FAIL b2b_addr[%0d]: got %0d accesses expected 1", k, addr_q.size());
      end
      tests_run++;
      if (bif1.if_data_o !== exp_d) begin
        tests_failed++; $display("FAIL b2b_data[%0d]: got %h expected %h", k, bif1.if_data_o, exp_d);
      end
    end
    drop_req();
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    test_reset();
    test_idle();
    test_fetch_only();
    test_data_fetch();
    test_write();
    test_reset_mid();
`ifdef ARB_IBUF_EN
    test_ibuf();
`endif
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1);
  end
endmodule
